fpu_result_collector: RTL and testbench
=======================================

Name: fpu_result_collector

Overview:
- Downstream stage of the FPU datapath. Captures each result word `g` in the cycle the FPU pulses `fi`, and classifies it (NaN/Inf/zero/denormal).
- Tags each result with a wrapping sequence number and buffers it in a FIFO drained through a valid/ready interface.
- Counts issues (`en`) against completions (`fi`) and drives `issue_ok`, so upstream never issues work whose result could find the FIFO full. The FPU cannot stall.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 4.
- TAG_W, 4, width of the sequence tag; wraps modulo 2^TAG_W.
- MAX_INFLIGHT, 4, maximum FPU operations in flight (the four staggered timing controllers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, clears all state.
- en  in  1  issue pulse, same signal driven into the FPU.
- fi  in  1  FPU finish pulse; `g` is valid in this cycle.
- g  in  32  FPU result, IEEE-754 single precision.
- out_rdy  in  1  consumer ready.
- err_clr  in  1  clears sticky error flags.
- out_vld  out  1  head entry valid.
- out_data  out  32  head result.
- out_flags  out  4  head classification {nan, inf, zero, denorm}.
- out_tag  out  TAG_W  head sequence tag.
- issue_ok  out  1  upstream may assert `en` this cycle.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- outstanding  out  $clog2(MAX_INFLIGHT)+1  issued-but-unfinished operations.
- err_ovf  out  1  sticky: a result was dropped because the FIFO was full.
- err_unf  out  1  sticky: `fi` arrived with outstanding==0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, outstanding=0, tag counter=0, head/tail pointers=0.
  - out_vld=0, out_data=0, out_flags=0, out_tag=0, err_ovf=0, err_unf=0.
  - A result in flight is lost; after release the block starts empty, with issue_ok=1.
- Capture:
  - On a rising edge with fi=1, write {g, flags(g), tag} at the tail when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - After a write: tail increments, tag counter increments modulo 2^TAG_W.
  - Latency: result written at edge N gives out_vld=1 and out_data=g in the cycle after edge N.
- Classification (exp=g[30:23], man=g[22:0]):
  - nan = exp==8'hFF and man!=0.
  - inf = exp==8'hFF and man==0.
  - zero = exp==0 and man==0.
  - denorm = exp==0 and man!=0.
  - Sign is ignored. Flags are stored with the entry.
- Drain:
  - A pop happens on an edge with out_vld & out_rdy; head increments.
  - out_data, out_flags and out_tag always reflect the head entry and stay stable while out_vld=1 and out_rdy=0.
  - out_vld = (count!=0).
- Simultaneous push and pop: count unchanged. This holds when full, so no drop. It also holds when empty, where the new entry appears the next cycle and is not bypassed.
- Overflow: fi=1 while count==DEPTH and no pop → entry discarded, tag not incremented, err_ovf set.
- Outstanding counter:
  - +1 on en, −1 on fi, unchanged when both occur in the same cycle.
  - en while outstanding==MAX_INFLIGHT and no fi → saturates and sets err_ovf.
  - fi while outstanding==0 → counter stays 0, err_unf set, result still captured normally.
- issue_ok = (count + outstanding) < DEPTH and outstanding < MAX_INFLIGHT; combinational from registered state.
- Sticky errors:
  - err_clr=1 clears both flags at the next edge.
  - A set event in the same cycle as err_clr wins, so the flag stays 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are resolved from `count`.

Decomposition:
- Package fpu_pkg holds:
  - FP_W=32, FP_EXP_W=8, FP_MAN_W=23, FP_EXP_MAX=8'hFF.
  - Flag bit indices FLG_NAN=3, FLG_INF=2, FLG_ZERO=1, FLG_DEN=0.
- One sub-module, fpu_result_fifo: a generic synchronous FIFO (width 32+4+TAG_W, DEPTH) with push/pop/count/full/empty ports.
- Classification, tag counter, outstanding counter and error logic stay in the top.

Test Plan:
- Reset, then en; 22 cycles later fi with g=32'h3F800000 → next cycle out_vld=1, out_data=32'h3F800000, out_flags=4'b0000, out_tag=0; outstanding goes 1→0.
- Four fi with g=7FC00000, 7F800000, 00000000, 00000001 and out_rdy=0 → flags 1000, 0100, 0010, 0001 with tags 0..3 in order; count=4.
- Fill to DEPTH=8 with out_rdy=0, then fi again → result dropped, err_ovf=1, count=8; then err_clr → err_ovf=0. Repeat with fi and out_rdy=1 in the same cycle → no drop, count stays 8.
- 17 captures with draining → tags run 0..15, then wrap to 0.
- fi with outstanding==0 → err_unf=1 and entry still captured. With outstanding=3 and count=5, issue_ok=0; after one pop, issue_ok=1.
- rst_n pulled low with count=5 and outstanding=2 → all outputs immediately 0 (asynchronous); after release, issue_ok=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU result-word constants and the result classifier.
// Latency: n/a (constants and a combinational helper function).
// Backpressure: n/a.
package fpu_pkg;

  localparam int FP_W       = 32;
  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  // Bit positions inside the 4-bit classification field {nan, inf, zero, denorm}
  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DEN  = 0;

  // Classify an IEEE-754 single; the sign bit plays no part
  function automatic logic [3:0] fp_classify(input logic [FP_W-1:0] x);
    logic [FP_EXP_W-1:0] exp_f;
    logic [FP_MAN_W-1:0] man_f;
    logic [3:0]          flg;
    exp_f = x[FP_W-2 -: FP_EXP_W];
    man_f = x[FP_MAN_W-1:0];
    flg = '0;
    flg[FLG_NAN]  = (exp_f == FP_EXP_MAX) && (man_f != '0);
    flg[FLG_INF]  = (exp_f == FP_EXP_MAX) && (man_f == '0);
    flg[FLG_ZERO] = (exp_f == '0) && (man_f == '0);
    flg[FLG_DEN]  = (exp_f == '0) && (man_f != '0);
    return flg;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic synchronous FIFO; read data is the head entry, forced to zero when empty.
// Latency: a pushed word is visible at the head the cycle after the push edge (no bypass).
// Backpressure: caller must not push when full without a same-cycle pop; pop only when not empty.
module fpu_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  // Gate the head so outputs read zero whenever nothing is held, including right at reset
  assign rdata = empty ? '0 : mem[head];

  // Storage array: written at the tail, never reset (validity comes from count)
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  // Pointers wrap naturally; occupancy alone separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_collector.sv
// Captures FPU results on fi, classifies and tags them, buffers them for a valid/ready consumer.
// Latency: result captured at edge N is presented at the head from the cycle after edge N.
// Backpressure: FPU cannot stall; issue_ok reserves FIFO room for every in-flight op, drops flag err_ovf.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TAG_W        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            fi,
  input  logic [FP_W-1:0]                 g,
  input  logic                            out_rdy,
  input  logic                            err_clr,
  output logic                            out_vld,
  output logic [FP_W-1:0]                 out_data,
  output logic [3:0]                      out_flags,
  output logic [TAG_W-1:0]                out_tag,
  output logic                            issue_ok,
  output logic [$clog2(DEPTH):0]          count,
  output logic [$clog2(MAX_INFLIGHT):0]   outstanding,
  output logic                            err_ovf,
  output logic                            err_unf
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int ENT_W = FP_W + 4 + TAG_W;
  localparam int SUM_W = CNT_W + 1;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic             ovf_issue;
  logic             unf_fin;
  logic [TAG_W-1:0] tag_cnt;
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] rd_ent;

  // A full FIFO still accepts a result when the consumer frees a slot on the same edge
  assign pop     = out_vld & out_rdy;
  assign push    = fi & (~fifo_full | pop);
  assign drop    = fi & fifo_full & ~pop;
  assign wr_ent  = {g, fp_classify(g), tag_cnt};

  fpu_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_vld   = ~fifo_empty;
  assign out_data  = rd_ent[ENT_W-1 -: FP_W];
  assign out_flags = rd_ent[TAG_W +: 4];
  assign out_tag   = rd_ent[TAG_W-1:0];

  // Every in-flight op needs a guaranteed FIFO slot, since its result cannot be held back
  assign issue_ok = ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH)) &&
                    (outstanding < OUT_W'(MAX_INFLIGHT));

  assign ovf_issue = en & ~fi & (outstanding == OUT_W'(MAX_INFLIGHT));
  assign unf_fin   = fi & (outstanding == '0);

  // Sequence tag advances only for results that actually land in the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  // Issue/finish balance; saturates at both ends and lets the error flags record the violation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (en && !fi && !ovf_issue) begin
      outstanding <= outstanding + 1'b1;
    end else if (fi && !en && !unf_fin) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Sticky error flags; a new event on the clearing edge keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= drop | ovf_issue | (err_ovf & ~err_clr);
      err_unf <= unf_fin | (err_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector with a queue-based reference model checked every cycle.
// Latency: model and DUT compared on the falling edge after each rising edge.
// Backpressure: out_rdy driven per vector; literal checks pin the model at key points.
module tb_fpu_result_collector;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        fi;
  logic [31:0] g;
  logic        out_rdy;
  logic        err_clr;
  logic        out_vld;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;
  logic        issue_ok;
  logic [3:0]  count;
  logic [2:0]  outstanding;
  logic        err_ovf;
  logic        err_unf;

  int checks = 0;
  int errors = 0;

  fpu_result_collector #(.DEPTH(8), .TAG_W(4), .MAX_INFLIGHT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fi          (fi),
    .g           (g),
    .out_rdy     (out_rdy),
    .err_clr     (err_clr),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .out_tag     (out_tag),
    .issue_ok    (issue_ok),
    .count       (count),
    .outstanding (outstanding),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    int          t;
  } ent_t;

  ent_t m_q[$];
  int   m_tag;
  int   m_out;
  bit   m_ovf;
  bit   m_unf;

  function automatic logic [3:0] ref_flags(input logic [31:0] x);
    int e;
    int m;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_tag = 0;
      m_out = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      bit   do_pop;
      bit   do_push;
      bit   ovf_ev;
      bit   unf_ev;
      ent_t e;
      do_pop  = (m_q.size() > 0) && out_rdy;
      do_push = fi && (m_q.size() < 8 || do_pop);
      ovf_ev  = fi && !do_push;
      unf_ev  = fi && (m_out == 0);
      if (en && !fi) begin
        if (m_out == 4) ovf_ev = 1;
        else            m_out++;
      end else if (fi && !en && m_out > 0) begin
        m_out--;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.d = g;
        e.f = ref_flags(g);
        e.t = m_tag;
        m_q.push_back(e);
        m_tag = (m_tag + 1) % 16;
      end
      m_ovf = ovf_ev || (m_ovf && !err_clr);
      m_unf = unf_ev || (m_unf && !err_clr);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = m_q.size();
      check("out_vld", 32'(out_vld), 32'(n != 0));
      check("count", 32'(count), 32'(n));
      check("outstanding", 32'(outstanding), 32'(m_out));
      check("issue_ok", 32'(issue_ok), 32'((n + m_out) < 8 && m_out < 4));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      check("err_unf", 32'(err_unf), 32'(m_unf));
      if (n != 0) begin
        check("out_data", out_data, m_q[0].d);
        check("out_flags", 32'(out_flags), 32'(m_q[0].f));
        check("out_tag", 32'(out_tag), 32'(m_q[0].t));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic e_i, input logic f_i, input logic [31:0] g_i,
                     input logic r_i, input logic c_i);
    en = e_i; fi = f_i; g = g_i; out_rdy = r_i; err_clr = c_i;
    @(posedge clk);
    #1;
    en = 0; fi = 0; g = '0; out_rdy = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #12;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_g [4];
  logic [3:0]  vec_f [4];

  initial begin
    rst_n = 0; en = 0; fi = 0; g = '0; out_rdy = 0; err_clr = 0;
    vec_g[0] = 32'h7FC00000; vec_f[0] = 4'b1000;
    vec_g[1] = 32'h7F800000; vec_f[1] = 4'b0100;
    vec_g[2] = 32'h00000000; vec_f[2] = 4'b0010;
    vec_g[3] = 32'h00000001; vec_f[3] = 4'b0001;

    // 1: reset state, single op with long FPU latency
    #3;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_issue_ok", 32'(issue_ok), 32'd1);
    do_reset();
    check("rel_issue_ok", 32'(issue_ok), 32'd1);
    cyc(1, 0, '0, 0, 0);
    check("t1_out_after_en", 32'(outstanding), 32'd1);
    repeat (21) cyc(0, 0, '0, 0, 0);
    cyc(0, 1, 32'h3F800000, 0, 0);
    check("t1_vld", 32'(out_vld), 32'd1);
    check("t1_data", out_data, 32'h3F800000);
    check("t1_flags", 32'(out_flags), 32'h0);
    check("t1_tag", 32'(out_tag), 32'h0);
    check("t1_out_after_fi", 32'(outstanding), 32'd0);

    // 2: classification of special values, tags in order
    do_reset();
    repeat (4) cyc(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, vec_g[i], 0, 0);
    check("t2_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_flags", 32'(out_flags), 32'(vec_f[i]));
      check("t2_tag", 32'(out_tag), 32'(i));
      cyc(0, 0, '0, 1, 0);
    end

    // 3: overflow drop, clear, and full push+pop
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 32'h40000000 + 32'(i), 0, 0);
    check("t3_full", 32'(count), 32'd8);
    cyc(0, 1, 32'hDEADBEEF, 0, 0);
    check("t3_ovf", 32'(err_ovf), 32'd1);
    check("t3_cnt_drop", 32'(count), 32'd8);
    cyc(0, 0, '0, 0, 1);
    check("t3_ovf_clr", 32'(err_ovf), 32'd0);
    cyc(0, 1, 32'h41000000, 1, 0);
    check("t3_cnt_pp", 32'(count), 32'd8);
    check("t3_ovf_pp", 32'(err_ovf), 32'd0);

    // 4: tag wrap over 17 captures while draining
    do_reset();
    for (int i = 0; i < 17; i++) cyc(0, 1, 32'h3F000000 + 32'(i), 1, 0);
    check("t4_count", 32'(count), 32'd1);
    check("t4_wrap_tag", 32'(out_tag), 32'd0);
    check("t4_wrap_data", out_data, 32'h3F000010);

    // 5: underflow still captures; issue_ok reservation
    do_reset();
    cyc(0, 1, 32'h3F800000, 0, 0);
    check("t5_unf", 32'(err_unf), 32'd1);
    check("t5_cnt", 32'(count), 32'd1);
    repeat (4) cyc(0, 1, 32'h3F800000, 0, 0);
    repeat (3) cyc(1, 0, '0, 0, 0);
    check("t5_cnt5", 32'(count), 32'd5);
    check("t5_issue_blk", 32'(issue_ok), 32'd0);
    cyc(0, 0, '0, 1, 0);
    check("t5_issue_ok", 32'(issue_ok), 32'd1);

    // 6: asynchronous reset mid-cycle
    cyc(0, 1, 32'h3F800000, 0, 0);
    check("t6_cnt", 32'(count), 32'd5);
    check("t6_out", 32'(outstanding), 32'd2);
    #3;
    rst_n = 0;
    #1;
    check("t6_vld", 32'(out_vld), 32'd0);
    check("t6_data", out_data, 32'd0);
    check("t6_tag", 32'(out_tag), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_outst", 32'(outstanding), 32'd0);
    check("t6_unf", 32'(err_unf), 32'd0);
    #10;
    rst_n = 1;
    @(posedge clk);
    #1;
    check("t6_issue_ok", 32'(issue_ok), 32'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
